seq_response_checker: RTL and testbench
=======================================

SEQ_RESPONSE_CHECKER -- requirements
Module: seq_response_checker

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of expected response vectors, range 2..16.
REQ-002 SHALL have parameter IW, default 4: width of the vector index and counters.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port START  input  1  begin a check run; level-sampled.
REQ-006 SHALL have port VALID  input  1  qualifies Y/Z as one sampled DUT response.
REQ-007 SHALL have port Y  input  1  DUT output Y under check.
REQ-008 SHALL have port Z  input  1  DUT output Z under check.
REQ-009 SHALL have port BUSY  output  1  high while in RUN.
REQ-010 SHALL have port DONE  output  1  high while in FIN.
REQ-011 SHALL have port PASS  output  1  high in FIN when ERR_CNT==0; otherwise 0.
REQ-012 SHALL have port IDX  output  IW  index of the next vector to compare.
REQ-013 SHALL have port ERR_CNT  output  IW+1  mismatch count, saturating.
REQ-014 SHALL have port FIRST_ERR  output  IW  index of the first mismatch.
REQ-015 SHALL have port FIRST_ERR_V  output  1  FIRST_ERR holds a captured index.

Function
REQ-016 SHALL implement an FSM with states IDLE=2'b00, RUN=2'b01, FIN=2'b10; encoding 2'b11 SHALL recover to IDLE on the next edge.
REQ-017 IDLE: START=1 -> RUN; IDX, ERR_CNT, FIRST_ERR, FIRST_ERR_V cleared on the same edge.
REQ-018 RUN, VALID=1: {Y,Z} compared with EXP[IDX]; mismatch increments ERR_CNT on that edge; IDX increments.
REQ-019 RUN, VALID=0: all state held; IDX does not advance.
REQ-020 First mismatch in a run: FIRST_ERR<=IDX, FIRST_ERR_V<=1; later mismatches do not change FIRST_ERR.
REQ-021 ERR_CNT saturates at 2**(IW+1)-1; no wrap-around.
REQ-022 RUN, VALID=1 with IDX==DEPTH-1: last compare performed, IDX wraps to 0, state -> FIN on that edge.
REQ-023 START while in RUN ignored; run is not restarted.
REQ-024 FIN: DONE=1, PASS=(ERR_CNT==0), results held until START=1, which restarts exactly as REQ-017.
REQ-025 All outputs registered or decoded from registered state only; ERR_CNT/FIRST_ERR reflect a sample one edge after it is presented.
REQ-026 Expected table EXP ({Y,Z}, index 0..7): 00, 01, 11, 10, 00, 11, 01, 10.

Reset
REQ-027 RST=0 SHALL immediately force state IDLE, BUSY=0, DONE=0, PASS=0, IDX=0, ERR_CNT=0, FIRST_ERR=0, FIRST_ERR_V=0, independent of CLK.
REQ-028 Reset asserted mid-run SHALL discard the partial run; no FIN is entered after release without a new START.
REQ-029 First rising edge after RST rises SHALL evaluate START normally.

Structure
REQ-030 Shared include seq_pkg.vh SHALL hold state encodings, DEPTH default, and the EXP table constants.
REQ-031 Expected table SHALL be a sub-module seq_exp_rom (combinational, address IW, data 2) instantiated once.
REQ-032 Control FSM, counters, and capture registers SHALL reside in seq_response_checker.

Verification
REQ-033 Clean run: START pulse, 8 VALID samples matching REQ-026 -> DONE=1, PASS=1, ERR_CNT=0, FIRST_ERR_V=0 after the 8th edge.
REQ-034 Errors: samples 2 and 5 inverted -> ERR_CNT=2, FIRST_ERR=2, FIRST_ERR_V=1, PASS=0.
REQ-035 Gaps: VALID low 3 cycles between samples 3 and 4 -> IDX holds at 4 during gap; final result identical to REQ-033.
REQ-036 Saturation: DEPTH=16, IW=4, 3 consecutive runs of all-wrong samples without restart of counters forced via override -> ERR_CNT sticks at 31, no wrap (single run: ERR_CNT=16).
REQ-037 Reset mid-run: RST=0 after sample 4 -> all outputs zero immediately; after release, no DONE until new START.
REQ-038 START during RUN and START in FIN: first ignored (IDX continues), second clears results and returns BUSY=1.

Source files
------------

// File: rtl/seq_response_checker_pkg.sv
// Shared definitions for the sequence response checker: FSM state
// encodings, default table depth and the expected {Y,Z} response table.
package seq_response_checker_pkg;

  // Encodings are fixed; 2'b11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } state_e;

  localparam int DEPTH_DEFAULT = 8;
  localparam int EXP_ENTRIES   = 8;

  // Expected {Y,Z} for a vector index. The base table has eight entries;
  // deeper configurations reuse it cyclically (index modulo eight).
  function automatic logic [1:0] exp_lookup(input int unsigned idx);
    logic [1:0] yz;
    case (idx % EXP_ENTRIES)
      0:       yz = 2'b00;
      1:       yz = 2'b01;
      2:       yz = 2'b11;
      3:       yz = 2'b10;
      4:       yz = 2'b00;
      5:       yz = 2'b11;
      6:       yz = 2'b01;
      default: yz = 2'b10;
    endcase
    return yz;
  endfunction

endpackage

// File: rtl/seq_response_checker_exp_rom.sv
// Combinational lookup of the expected {Y,Z} response for a vector index.
module seq_exp_rom
  import seq_response_checker_pkg::*;
#(
  parameter int IW = 4
) (
  input  logic [IW-1:0] addr_i,
  output logic [1:0]    data_o
);

  // Pure table decode; no state.
  always_comb begin
    data_o = exp_lookup(32'(addr_i));
  end

endmodule

// File: rtl/seq_response_checker.sv
// Sequence response checker: after START, compares DEPTH qualified {Y,Z}
// samples against the expected table, counts mismatches (saturating),
// records the index of the first mismatch and reports PASS/DONE.
module seq_response_checker
  import seq_response_checker_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEFAULT,
  parameter int IW         = 4,
  // When set, ERR_CNT is not cleared by START and accumulates across runs.
  parameter bit ACCUMULATE = 1'b0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          VALID,
  input  logic          Y,
  input  logic          Z,
  output logic          BUSY,
  output logic          DONE,
  output logic          PASS,
  output logic [IW-1:0] IDX,
  output logic [IW:0]   ERR_CNT,
  output logic [IW-1:0] FIRST_ERR,
  output logic          FIRST_ERR_V
);

  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
  localparam logic [IW:0]   ERR_MAX  = '1;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW:0]   err_cnt_q, err_cnt_d;
  logic [IW-1:0] first_err_q, first_err_d;
  logic          first_err_v_q, first_err_v_d;
  logic [1:0]    exp_yz;
  logic          mismatch;

  seq_exp_rom #(.IW(IW)) u_exp_rom (
    .addr_i (idx_q),
    .data_o (exp_yz)
  );

  // Next-state logic for the control FSM, index counter and capture registers.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d       = state_q;
    idx_d         = idx_q;
    err_cnt_d     = err_cnt_q;
    first_err_d   = first_err_q;
    first_err_v_d = first_err_v_q;
    mismatch      = VALID && ({Y, Z} != exp_yz);

    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (START) begin
          state_d       = ST_RUN;
          idx_d         = '0;
          err_cnt_d     = ACCUMULATE ? err_cnt_q : '0;
          first_err_d   = '0;
          first_err_v_d = 1'b0;
        end
      end
      ST_RUN: begin
        // START is ignored here; only qualified samples advance the run.
        if (VALID) begin
          if (mismatch) begin
            if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 1'b1;
            if (!first_err_v_q) begin
              first_err_d   = idx_q;
              first_err_v_d = 1'b1;
            end
          end
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_FIN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; asynchronous reset discards any partial run.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      err_cnt_q     <= '0;
      first_err_q   <= '0;
      first_err_v_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the
      // same pre-edge values.
      state_q       <= state_d;
      idx_q         <= idx_d;
      err_cnt_q     <= err_cnt_d;
      first_err_q   <= first_err_d;
      first_err_v_q <= first_err_v_d;
    end
  end

  // Outputs are registers or decodes of registered state only.
  always_comb begin
    BUSY        = (state_q == ST_RUN);
    DONE        = (state_q == ST_FIN);
    PASS        = (state_q == ST_FIN) && (err_cnt_q == '0);
    IDX         = idx_q;
    ERR_CNT     = err_cnt_q;
    FIRST_ERR   = first_err_q;
    FIRST_ERR_V = first_err_v_q;
  end

endmodule

// File: tb/tb_seq_response_checker.sv
// Testbench for seq_response_checker: directed runs with hand-computed
// results queued as expectations; monitors compare when DONE rises.
module tb_seq_response_checker;

  localparam int IW = 4;

  typedef struct {
    int err;
    int ferr;
    int fv;
    int pass;
  } res_t;

  // Hand-written expected {Y,Z} table, index 0..7.
  logic [1:0] exp_tb [8] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b11, 2'b01, 2'b10};

  logic          CLK;
  logic          RST;
  logic          START, VALID, Y, Z;
  logic          BUSY, DONE, PASS, FIRST_ERR_V;
  logic [IW-1:0] IDX, FIRST_ERR;
  logic [IW:0]   ERR_CNT;

  logic          s_start, s_valid, s_y, s_z;
  logic          s_busy, s_done, s_pass, s_first_err_v;
  logic [IW-1:0] s_idx, s_first_err;
  logic [IW:0]   s_err_cnt;

  int   n_tests = 0;
  int   n_fail  = 0;
  res_t q_main[$];
  res_t q_sat[$];

  seq_response_checker #(.DEPTH(8), .IW(IW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .VALID(VALID), .Y(Y), .Z(Z),
    .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .IDX(IDX), .ERR_CNT(ERR_CNT),
    .FIRST_ERR(FIRST_ERR), .FIRST_ERR_V(FIRST_ERR_V)
  );

  seq_response_checker #(.DEPTH(16), .IW(IW), .ACCUMULATE(1'b1)) dut_sat (
    .CLK(CLK), .RST(RST), .START(s_start), .VALID(s_valid), .Y(s_y), .Z(s_z),
    .BUSY(s_busy), .DONE(s_done), .PASS(s_pass), .IDX(s_idx), .ERR_CNT(s_err_cnt),
    .FIRST_ERR(s_first_err), .FIRST_ERR_V(s_first_err_v)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare results of the main checker each time DONE rises.
  logic done_prev = 1'b0;
  always @(negedge CLK) begin
    if (DONE && !done_prev) begin
      if (q_main.size() == 0) begin
        check("main_unexpected_done", 1, 0);
      end else begin
        res_t r;
        r = q_main.pop_front();
        check("main_err_cnt", int'(ERR_CNT), r.err);
        check("main_first_err", int'(FIRST_ERR), r.ferr);
        check("main_first_err_v", int'(FIRST_ERR_V), r.fv);
        check("main_pass", int'(PASS), r.pass);
      end
    end
    done_prev = DONE;
  end

  // Monitor: compare results of the saturation checker each time DONE rises.
  logic s_done_prev = 1'b0;
  always @(negedge CLK) begin
    if (s_done && !s_done_prev) begin
      if (q_sat.size() == 0) begin
        check("sat_unexpected_done", 1, 0);
      end else begin
        res_t r;
        r = q_sat.pop_front();
        check("sat_err_cnt", int'(s_err_cnt), r.err);
        check("sat_first_err", int'(s_first_err), r.ferr);
        check("sat_first_err_v", int'(s_first_err_v), r.fv);
        check("sat_pass", int'(s_pass), r.pass);
      end
    end
    s_done_prev = s_done;
  end

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_pulse();
    START = 1'b1;
    cycle();
    START = 1'b0;
  endtask

  task automatic sample(input logic [1:0] yz);
    VALID = 1'b1;
    {Y, Z} = yz;
    cycle();
    VALID = 1'b0;
  endtask

  task automatic push_main(input int err, input int ferr, input int fv, input int pass);
    res_t r;
    r.err = err; r.ferr = ferr; r.fv = fv; r.pass = pass;
    q_main.push_back(r);
  endtask

  task automatic sat_run();
    s_start = 1'b1;
    cycle();
    s_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1;
      {s_y, s_z} = ~exp_tb[i % 8];
      cycle();
    end
    s_valid = 1'b0;
    cycle();
  endtask

  initial begin
    res_t r;
    RST = 1'b0;
    START = 1'b0; VALID = 1'b0; Y = 1'b0; Z = 1'b0;
    s_start = 1'b0; s_valid = 1'b0; s_y = 1'b0; s_z = 1'b0;

    // Reset state.
    #12;
    check("rst_busy", int'(BUSY), 0);
    check("rst_done", int'(DONE), 0);
    check("rst_pass", int'(PASS), 0);
    check("rst_idx", int'(IDX), 0);
    check("rst_err_cnt", int'(ERR_CNT), 0);
    check("rst_first_err_v", int'(FIRST_ERR_V), 0);
    @(posedge CLK); #1;
    RST = 1'b1;
    cycle();

    // Clean run.
    push_main(0, 0, 0, 1);
    start_pulse();
    check("clean_busy", int'(BUSY), 1);
    check("clean_idx0", int'(IDX), 0);
    for (int i = 0; i < 8; i++) sample(exp_tb[i]);
    check("clean_done", int'(DONE), 1);
    check("clean_idx_wrap", int'(IDX), 0);
    cycle();

    // Samples 2 and 5 inverted.
    push_main(2, 2, 1, 0);
    start_pulse();
    for (int i = 0; i < 8; i++) sample((i == 2 || i == 5) ? ~exp_tb[i] : exp_tb[i]);
    cycle();

    // Gap of three idle cycles between samples 3 and 4.
    push_main(0, 0, 0, 1);
    start_pulse();
    for (int i = 0; i < 4; i++) sample(exp_tb[i]);
    for (int g = 0; g < 3; g++) begin
      check("gap_idx_hold", int'(IDX), 4);
      cycle();
    end
    for (int i = 4; i < 8; i++) sample(exp_tb[i]);
    check("gap_done", int'(DONE), 1);
    cycle();

    // Reset mid-run after four samples, one of them wrong.
    start_pulse();
    for (int i = 0; i < 4; i++) sample((i == 1) ? ~exp_tb[i] : exp_tb[i]);
    check("midrst_pre_idx", int'(IDX), 4);
    check("midrst_pre_err", int'(ERR_CNT), 1);
    RST = 1'b0;
    #1;
    check("midrst_busy", int'(BUSY), 0);
    check("midrst_idx", int'(IDX), 0);
    check("midrst_err_cnt", int'(ERR_CNT), 0);
    check("midrst_first_err", int'(FIRST_ERR), 0);
    check("midrst_first_err_v", int'(FIRST_ERR_V), 0);
    cycle();
    RST = 1'b1;
    for (int i = 4; i < 12; i++) begin
      sample(exp_tb[i % 8]);
      check("midrst_no_done", int'(DONE), 0);
      check("midrst_no_busy", int'(BUSY), 0);
    end

    // START during RUN ignored; START in FIN restarts and clears results.
    push_main(2, 2, 1, 0);
    start_pulse();
    for (int i = 0; i < 8; i++) begin
      START = (i == 3);
      sample((i == 2 || i == 5) ? ~exp_tb[i] : exp_tb[i]);
      START = 1'b0;
      if (i == 3) check("run_start_ignored_idx", int'(IDX), 4);
    end
    cycle();
    start_pulse();
    check("fin_restart_busy", int'(BUSY), 1);
    check("fin_restart_done", int'(DONE), 0);
    check("fin_restart_err", int'(ERR_CNT), 0);
    check("fin_restart_fv", int'(FIRST_ERR_V), 0);
    check("fin_restart_idx", int'(IDX), 0);

    // Saturation: three accumulating runs of 16 wrong samples.
    r.err = 16; r.ferr = 0; r.fv = 1; r.pass = 0;
    q_sat.push_back(r);
    sat_run();
    r.err = 31;
    q_sat.push_back(r);
    sat_run();
    q_sat.push_back(r);
    sat_run();

    // Bounded wait for every queued expectation to be consumed.
    for (int k = 0; k < 50 && (q_main.size() != 0 || q_sat.size() != 0); k++) cycle();
    check("main_queue_drained", q_main.size(), 0);
    check("sat_queue_drained", q_sat.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
